// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart TX arbiter: FSM state encoding and tag width.
// The tag word layout is {zero pad, grant_id} in UartArbTagWidth low bits.
package uart_tx_arbiter_pkg;

    localparam int unsigned UartMaxData     = 8;
    localparam int unsigned UartArbTagWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StTag  = 2'd2,
        StXfer = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: returns the first set bit of mask_i, scanning upward
// from ptr_i+1 modulo N, plus a found flag.
module rr_priority_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        logic [W-1:0] cand;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = W'((32'(ptr_i) + k) % N);
            if (!found_o && mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart TX FIFO among NUM_REQ clients.
// Define UART_ARB_TAG_EN to prefix every grant with a {zero pad, grant_id} tag word.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = UartMaxData,
    parameter int unsigned MAX_BURST  = 64,
    localparam int unsigned GW = $clog2(NUM_REQ),
    localparam int unsigned CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_write_o,
    input  logic                          tx_full_i,
    input  logic                          tx_almost_full_i,
    output logic [GW-1:0]                 grant_id_o,
    output logic                          busy_o
);

    arb_state_e state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [CW-1:0]         burst_q, burst_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_write_q, tx_write_d;

    logic [GW-1:0]         pick_idx;
    logic                  pick_found;
    logic                  fifo_ok;
    logic                  cur_valid, cur_last;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  xfer_fire, burst_done, release_grant, tag_fire;

    rr_priority_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .mask_i (req_valid_i),
        .ptr_i  (rr_q),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    // almost_full reserves the slot taken by the write already sitting in tx_write_q
    assign fifo_ok = !tx_full_i && !tx_almost_full_i;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                cur_valid = req_valid_i[i];
                cur_last  = req_last_i[i];
                cur_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer_fire     = (state_q == StXfer) && fifo_ok && cur_valid;
    assign burst_done    = (MAX_BURST != 0) && (burst_q == CW'(MAX_BURST - 1));
    assign release_grant = xfer_fire && (cur_last || burst_done);

`ifdef UART_ARB_TAG_EN
    assign tag_fire = (state_q == StTag) && fifo_ok;
`else
    assign tag_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid_i) state_d = StArb;
            end
            StArb: begin
                if (pick_found) begin
`ifdef UART_ARB_TAG_EN
                    state_d = StTag;
`else
                    state_d = StXfer;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StTag: begin
`ifdef UART_ARB_TAG_EN
                if (tag_fire) state_d = StXfer;
`else
                state_d = StIdle;
`endif
            end
            StXfer: begin
                if (release_grant) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = (state_q == StXfer) && fifo_ok && (grant_q == GW'(i));
        end
        busy_o = (state_q != StIdle);

        grant_d    = grant_q;
        rr_d       = rr_q;
        burst_d    = burst_q;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;

        if ((state_q == StArb) && pick_found) grant_d = pick_idx;
`ifdef UART_ARB_TAG_EN
        if (tag_fire) begin
            logic [UartArbTagWidth-1:0] tag_id;
            tag_id     = UartArbTagWidth'(grant_q);
            tx_write_d = 1'b1;
            tx_data_d  = DATA_WIDTH'(tag_id);
        end
`endif
        if (xfer_fire) begin
            tx_write_d = 1'b1;
            tx_data_d  = cur_data;
            burst_d    = burst_q + CW'(1);
        end
        if (release_grant) begin
            rr_d    = grant_q;
            burst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= '0;
            rr_q       <= GW'(NUM_REQ - 1);
            burst_q    <= '0;
            tx_data_q  <= '0;
            tx_write_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            burst_q    <= burst_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_write_o = tx_write_q;
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 clients, 8-bit words, MAX_BURST=4):
// cycle table for reset/latency/flags, then queue-driven packet sequences.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid, last, ready;
    logic [31:0] data;
    logic [7:0]  txd;
    logic        txw, full, af, busy;
    logic [1:0]  gnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (valid),
        .req_data_i      (data),
        .req_last_i      (last),
        .req_ready_o     (ready),
        .tx_data_o       (txd),
        .tx_write_o      (txw),
        .tx_full_i       (full),
        .tx_almost_full_i(af),
        .grant_id_o      (gnt),
        .busy_o          (busy)
    );

    typedef struct {
        logic [3:0] v;
        logic       f;
        logic       a;
        logic [3:0] rdy;
        logic       wr;
        logic [7:0] d;
        logic [1:0] g;
        logic       b;
    } vec_t;

    typedef struct packed {
        logic       last;
        logic [7:0] d;
    } word_t;

    vec_t       tbl[22];
    word_t      cq[4][$];
    logic [3:0] hold = '0;
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] expq[$];
    int         fires[4];
    int         cyc = 0;
    logic [3:0] rdy_s;
    logic       txw_s;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (cq[i].size() > 0) begin
                valid[i]         = !hold[i];
                data[i*8 +: 8]   = cq[i][0].d;
                last[i]          = cq[i][0].last;
            end else begin
                valid[i]         = 1'b0;
                data[i*8 +: 8]   = 8'h00;
                last[i]          = 1'b0;
            end
        end
    endtask

    // One clock: sample handshake at negedge, retire words and log tx after the edge.
    task automatic tick();
        logic [3:0] fire;
        drive();
        @(negedge clk);
        fire  = valid & ready;
        rdy_s = ready;
        txw_s = txw;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                void'(cq[i].pop_front());
                fires[i]++;
            end
        end
        if (txw) begin
            got.push_back(txd);
            got_cyc.push_back(cyc);
        end
        drive();
    endtask

    task automatic run_until(int n, int budget, string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, " word count"}, got.size(), n);
    endtask

    task automatic wait_fire(int c, int budget, string name);
        int k = 0;
        while (fires[c] < 1 && k < budget) begin
            tick();
            k++;
        end
        check({name, " first transfer"}, 32'(fires[c] >= 1), 1);
    endtask

    task automatic cmp_got(string name);
        check({name, " length"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            check($sformatf("%s word %0d", name, i), got[i], expq[i]);
        end
        got.delete();
        got_cyc.delete();
        expq.delete();
    endtask

    task automatic exp_tag(int c);
        if (TAG != 0) expq.push_back(8'(c));
    endtask

    task automatic clear_fires();
        for (int i = 0; i < 4; i++) fires[i] = 0;
    endtask

    initial begin
        // v, full, af, ready, tx_write, tx_data, grant, busy
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[2]  = '{4'hF, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[3]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 8'h10, 2'd0, 1'b0};
        tbl[4]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[5]  = '{4'hF, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[7]  = '{4'hF, 1'b0, 1'b0, 4'h2, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[8]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1, 1'b0};
        tbl[9]  = '{4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[10] = '{4'hB, 1'b0, 1'b0, 4'h4, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[11] = '{4'hF, 1'b0, 1'b0, 4'h4, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[12] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h12, 2'd2, 1'b0};
        tbl[13] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[14] = '{4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[15] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[16] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[17] = '{4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[18] = '{4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[19] = '{4'h8, 1'b0, 1'b0, 4'h8, 1'b0, 8'h00, 2'd3, 1'b1};
        tbl[20] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h13, 2'd3, 1'b0};
        tbl[21] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};

        clear_fires();
        valid = 4'hF;
        last  = 4'hF;
        data  = 32'h1312_1110;
        full  = 1'b0;
        af    = 1'b0;
        rst   = 1'b1;

        // Reset held with every client requesting
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset%0d ready", k), ready, 0);
            check($sformatf("reset%0d tx_write", k), txw, 0);
            check($sformatf("reset%0d busy", k), busy, 0);
            check($sformatf("reset%0d grant", k), gnt, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

`ifndef UART_ARB_TAG_EN
        for (int i = 0; i < 22; i++) begin
            valid = tbl[i].v;
            full  = tbl[i].f;
            af    = tbl[i].a;
            @(negedge clk);
            check($sformatf("tbl%0d ready", i), ready, tbl[i].rdy);
            check($sformatf("tbl%0d tx_write", i), txw, tbl[i].wr);
            if (tbl[i].wr) check($sformatf("tbl%0d tx_data", i), txd, tbl[i].d);
            check($sformatf("tbl%0d grant", i), gnt, tbl[i].g);
            check($sformatf("tbl%0d busy", i), busy, tbl[i].b);
            @(posedge clk);
            #1;
        end
`endif
        full = 1'b0;
        af   = 1'b0;

        // Rotation: every client queues two 2-word packets
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                cq[c].push_back({1'b0, 8'(c * 16 + p * 2)});
                cq[c].push_back({1'b1, 8'(c * 16 + p * 2 + 1)});
                exp_tag(c);
                expq.push_back(8'(c * 16 + p * 2));
                expq.push_back(8'(c * 16 + p * 2 + 1));
            end
        end
        run_until(16 + 8 * TAG, 300, "rotation");
`ifndef UART_ARB_TAG_EN
        for (int k = 1; k < got_cyc.size(); k++) begin
            check($sformatf("rotation spacing %0d", k), got_cyc[k] - got_cyc[k-1],
                  (k % 2 == 1) ? 1 : 3);
        end
`endif
        cmp_got("rotation");

        // Backpressure mid-packet from client 1
        clear_fires();
        cq[1].push_back({1'b0, 8'h30});
        cq[1].push_back({1'b0, 8'h31});
        cq[1].push_back({1'b1, 8'h32});
        exp_tag(1);
        expq.push_back(8'h30);
        expq.push_back(8'h31);
        expq.push_back(8'h32);
        wait_fire(1, 20, "backpressure");
        af = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("almost_full%0d ready", k), rdy_s, 0);
        end
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("full%0d ready", k), rdy_s, 0);
            check($sformatf("full%0d tx_write", k), txw_s, 0);
        end
        full = 1'b0;
        af   = 1'b0;
        run_until(3 + TAG, 40, "backpressure");
        cmp_got("backpressure");

        // Burst limit: client 1 streams 10 words, client 2 arrives after it starts
        clear_fires();
        for (int k = 0; k < 10; k++) cq[1].push_back({k == 9, 8'(8'h40 + k)});
        wait_fire(1, 20, "burst");
        cq[2].push_back({1'b0, 8'h50});
        cq[2].push_back({1'b1, 8'h51});
        exp_tag(1);
        for (int k = 0; k < 4; k++) expq.push_back(8'(8'h40 + k));
        exp_tag(2);
        expq.push_back(8'h50);
        expq.push_back(8'h51);
        exp_tag(1);
        for (int k = 4; k < 8; k++) expq.push_back(8'(8'h40 + k));
        exp_tag(1);
        expq.push_back(8'h48);
        expq.push_back(8'h49);
        run_until(12 + 4 * TAG, 200, "burst");
        cmp_got("burst");

        // Atomicity: granted client 0 stalls while client 3 waits
        clear_fires();
        cq[0].push_back({1'b0, 8'h60});
        cq[0].push_back({1'b0, 8'h61});
        cq[0].push_back({1'b1, 8'h62});
        wait_fire(0, 20, "atomic");
        hold[0] = 1'b1;
        cq[3].push_back({1'b1, 8'h70});
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("atomic stall%0d ready", k), rdy_s, 4'b0001);
        end
        hold[0] = 1'b0;
        exp_tag(0);
        expq.push_back(8'h60);
        expq.push_back(8'h61);
        expq.push_back(8'h62);
        exp_tag(3);
        expq.push_back(8'h70);
        run_until(4 + 2 * TAG, 60, "atomic");
        cmp_got("atomic");

        // Client 2 packet; prefixed by its id when tagging is built in
        cq[2].push_back({1'b0, 8'hA5});
        cq[2].push_back({1'b1, 8'h5A});
        exp_tag(2);
        expq.push_back(8'hA5);
        expq.push_back(8'h5A);
        run_until(2 + TAG, 40, "tag");
        cmp_got("tag");

        // Reset while a transfer is being accepted
        clear_fires();
        cq[0].push_back({1'b0, 8'h80});
        cq[0].push_back({1'b0, 8'h81});
        cq[0].push_back({1'b1, 8'h82});
        wait_fire(0, 20, "midreset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset tx_write", txw, 0);
        check("midreset busy", busy, 0);
        check("midreset ready", ready, 0);
        check("midreset grant", gnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cq[i].delete();
        got.delete();
        got_cyc.delete();
        // Pointer is back at NUM_REQ-1, so client 1 beats client 3
        cq[3].push_back({1'b1, 8'h93});
        cq[1].push_back({1'b1, 8'h91});
        exp_tag(1);
        expq.push_back(8'h91);
        exp_tag(3);
        expq.push_back(8'h93);
        run_until(2 + 2 * TAG, 40, "postreset");
        cmp_got("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
